mod_74x161_counter: RTL and testbench
=====================================

Name: mod_74x161_counter

Overview:
- Synchronous binary counter in the 74x161 style: asynchronous clear, synchronous parallel load, count-enable pair (ENP, ENT) and ripple-carry output (RCO).
- Sits downstream of the 74x08 AND-gate stage. Two-input AND gates combine enable terms to drive ENP/ENT.
- RCO of one counter, ANDed with a global enable, drives ENT of the next counter to build wider cascaded counters.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 1.

Ports:
- CLK  input  1  clock; all state changes on rising edge except clear.
- CLR  input  1  reset, asynchronous, active-high; forces Q to 0.
- LOAD  input  1  synchronous parallel load, active-high.
- ENP  input  1  count enable P (parallel enable), active-high.
- ENT  input  1  count enable T (trickle enable), active-high; also gates RCO.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  registered counter value.
- RCO  output  1  ripple carry out, combinational.

Behaviour:
- Clock and reset: one clock CLK; reset CLR is asynchronous and active-high.
- CLR asserted:
  - Q = 0 immediately, with no clock edge required.
  - Q is held at 0 while CLR is high; clock edges, LOAD and enables are ignored.
  - RCO = 0 as a consequence of Q = 0 (for WIDTH >= 1).
- Reset release: the first rising CLK edge with CLR low is a normal functional edge. No extra latency cycle.
- Rising CLK edge with CLR low, priority order:
  1. LOAD = 1: Q <= D. ENP and ENT are ignored, so a load with both enables low still loads.
  2. Otherwise, if ENP = 1 and ENT = 1: Q <= Q + 1, modulo 2^WIDTH. All-ones wraps to 0.
  3. Otherwise: Q holds.
- Latency: Q reflects a load or increment one edge after the control is sampled. Inputs are sampled only at the edge; glitches between edges have no effect.
- RCO:
  - RCO = ENT AND (Q == all ones). Pure combinational; no dependence on ENP or LOAD.
  - RCO follows ENT within the same cycle, with no register.
  - Terminal count is reached when Q = 2^WIDTH-1. RCO is high that whole cycle if ENT = 1. On the next counting edge Q wraps to 0 and RCO falls.
- Simultaneous events:
  - CLR asserted coincident with a CLK edge: clear wins, Q = 0.
  - LOAD with D = all ones and ENT = 1: RCO goes high in the cycle after the load.
- Mid-operation clear: CLR asserted mid-count discards the count. The count resumes from 0 after release.
- Cascade contract: the counter makes no assumption about the source of ENT. Q and RCO must be glitch-free under steady ENT, so no combinational path from CLK to RCO other than through Q.
- X handling: none required. Outputs must be defined (0) from the moment CLR is first asserted.

Test Plan:
- Async clear: count to Q=5, raise CLR between edges -> Q=0 and RCO=0 before the next edge. Hold CLR over 3 edges with LOAD=1, D=9 -> Q stays 0.
- Load priority: CLR=0, LOAD=1, ENP=0, ENT=0, D=4'hA, one edge -> Q=4'hA. Repeat with ENP=ENT=1, D=3 -> Q=3, not 4.
- Count and wrap: load 4'hD, then LOAD=0, ENP=ENT=1 for 4 edges -> Q sequence E, F, 0, 1. RCO=1 only while Q=F.
- Enable gating: at Q=6, ENP=1/ENT=0 for 2 edges -> Q=6. ENP=0/ENT=1 for 2 edges -> Q=6. Both high, 1 edge -> Q=7.
- RCO gating: load F, ENP=0. Toggle ENT 1/0/1 between edges -> RCO follows 1/0/1 combinationally while Q stays F.
- Cascade with the AND stage: two instances, WIDTH=4, with ENT of the upper counter = AND(RCO_low, 1). Start from 0 with both enables high; after 16 edges -> upper Q=1, lower Q=0. After 255 edges from start -> both Q=F.

Source files
------------

// File: rtl/mod_74x161_counter.sv
// 74x161-style synchronous binary counter: async clear, synchronous load,
// ENP/ENT count enables and a combinational ripple-carry output for cascading.
module mod_74x161_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load beats counting; both enables must be high to advance.
    always_comb begin
        // NOTE: default assignment first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (LOAD) begin
            count_d = D;
        end else if (ENP && ENT) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        // NOTE: non-blocking assignment for state so all flops update together at the edge.
        if (CLR) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Q = count_q;

    // Only Q and ENT feed RCO, so there is no direct CLK path into the carry chain.
    assign RCO = ENT && (count_q == '1);

endmodule

// File: tb/tb_mod_74x161_counter.sv
// Directed self-checking bench for mod_74x161_counter, including a two-stage
// cascade built with an AND gate feeding the upper counter's ENT.
module tb_mod_74x161_counter;

    logic       CLK;
    logic       CLR;
    logic       LOAD;
    logic       ENP;
    logic       ENT;
    logic [3:0] D;
    logic [3:0] Q;
    logic       RCO;

    logic       cas_clr;
    logic       cas_en;
    logic       cas_gate;
    logic [3:0] lo_q;
    logic [3:0] hi_q;
    logic       lo_rco;
    logic       hi_rco;
    logic       hi_ent;
    logic [3:0] zero_d;

    int total  = 0;
    int passes = 0;

    mod_74x161_counter #(.WIDTH(4)) dut (
        .CLK(CLK), .CLR(CLR), .LOAD(LOAD), .ENP(ENP), .ENT(ENT),
        .D(D), .Q(Q), .RCO(RCO)
    );

    assign hi_ent = lo_rco & cas_gate;
    assign zero_d = 4'h0;

    mod_74x161_counter #(.WIDTH(4)) u_lo (
        .CLK(CLK), .CLR(cas_clr), .LOAD(1'b0), .ENP(cas_en), .ENT(cas_en),
        .D(zero_d), .Q(lo_q), .RCO(lo_rco)
    );

    mod_74x161_counter #(.WIDTH(4)) u_hi (
        .CLK(CLK), .CLR(cas_clr), .LOAD(1'b0), .ENP(cas_en), .ENT(hi_ent),
        .D(zero_d), .Q(hi_q), .RCO(hi_rco)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        CLR = 1'b1; LOAD = 1'b0; ENP = 1'b0; ENT = 1'b0; D = 4'h0;
        cas_clr = 1'b1; cas_en = 1'b1; cas_gate = 1'b1;
        #2;
        check("reset_q", {4'h0, Q}, 8'h00);
        check("reset_rco", {7'h0, RCO}, 8'h00);

        // Count up to 5, then clear asynchronously between edges.
        CLR = 1'b0; ENP = 1'b1; ENT = 1'b1;
        step(5);
        check("count_to_5", {4'h0, Q}, 8'h05);
        #2 CLR = 1'b1;
        #1;
        check("async_clr_q", {4'h0, Q}, 8'h00);
        check("async_clr_rco", {7'h0, RCO}, 8'h00);
        LOAD = 1'b1; D = 4'h9;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("clr_hold_%0d", i), {4'h0, Q}, 8'h00);
        end

        // Load priority; first edge after release is functional.
        CLR = 1'b0; LOAD = 1'b1; ENP = 1'b0; ENT = 1'b0; D = 4'hA;
        step();
        check("load_no_en", {4'h0, Q}, 8'h0A);
        ENP = 1'b1; ENT = 1'b1; D = 4'h3;
        step();
        check("load_over_count", {4'h0, Q}, 8'h03);

        // Count and wrap from D.
        D = 4'hD;
        step();
        check("load_d", {4'h0, Q}, 8'h0D);
        LOAD = 1'b0;
        check("rco_at_d", {7'h0, RCO}, 8'h00);
        step(); check("wrap_e", {4'h0, Q}, 8'h0E); check("rco_e", {7'h0, RCO}, 8'h00);
        step(); check("wrap_f", {4'h0, Q}, 8'h0F); check("rco_f", {7'h0, RCO}, 8'h01);
        step(); check("wrap_0", {4'h0, Q}, 8'h00); check("rco_0", {7'h0, RCO}, 8'h00);
        step(); check("wrap_1", {4'h0, Q}, 8'h01); check("rco_1", {7'h0, RCO}, 8'h00);

        // Enable gating at Q=6.
        LOAD = 1'b1; D = 4'h6;
        step();
        LOAD = 1'b0; ENP = 1'b1; ENT = 1'b0;
        step(2);
        check("enp_only", {4'h0, Q}, 8'h06);
        ENP = 1'b0; ENT = 1'b1;
        step(2);
        check("ent_only", {4'h0, Q}, 8'h06);
        ENP = 1'b1;
        step();
        check("both_en", {4'h0, Q}, 8'h07);

        // RCO follows ENT combinationally at terminal count; independent of LOAD.
        LOAD = 1'b1; D = 4'hF; ENP = 1'b0; ENT = 1'b1;
        step();
        LOAD = 1'b0;
        check("load_f_rco", {7'h0, RCO}, 8'h01);
        #1 ENT = 1'b0; #1;
        check("rco_ent0", {7'h0, RCO}, 8'h00);
        ENT = 1'b1; #1;
        check("rco_ent1", {7'h0, RCO}, 8'h01);
        LOAD = 1'b1; D = 4'h0; #1;
        check("rco_ignores_load", {7'h0, RCO}, 8'h01);
        LOAD = 1'b0;
        check("rco_hold_q", {4'h0, Q}, 8'h0F);

        // Clear coincident with a clock edge, then resume from 0.
        LOAD = 1'b1; D = 4'h3;
        step();
        LOAD = 1'b0; ENP = 1'b1; ENT = 1'b1;
        @(posedge CLK);
        CLR = 1'b1;
        #2;
        check("clr_at_edge", {4'h0, Q}, 8'h00);
        #1 CLR = 1'b0;
        step();
        check("resume_after_clr", {4'h0, Q}, 8'h01);

        // Cascade: 16 edges carry once into the upper counter, 255 edges fill both.
        cas_clr = 1'b0;
        step(16);
        check("cas16_hi", {4'h0, hi_q}, 8'h01);
        check("cas16_lo", {4'h0, lo_q}, 8'h00);
        step(239);
        check("cas255_val", {hi_q, lo_q}, 8'hFF);
        check("cas255_hi_rco", {7'h0, hi_rco}, 8'h01);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
